// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one sync_fifo write port
// among NUM_REQ valid/ready producers. It holds each grant for up to
// MAX_BURST accepted beats, then rotates. The FIFO full flag back-pressures
// the granted producer.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic                            fifo_full,
   output logic                            fifo_wr_en,
   output logic [DATA_WIDTH-1:0]           fifo_din,
   output logic                            grant_active,
   output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

   localparam int          GW = $clog2(NUM_REQ);
   localparam int          BW = $clog2(MAX_BURST) + 1;
   localparam int unsigned NR = NUM_REQ;
   localparam int unsigned DW = DATA_WIDTH;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state, state_nxt;
   logic [GW-1:0]   grant_id_nxt;
   logic [GW-1:0]   last_grant, last_grant_nxt;
   logic [BW-1:0]   beat_cnt, beat_cnt_nxt;

   logic            accept;
   logic            grant_end;
   logic [GW-1:0]   arb_ptr;
   logic [GW-1:0]   arb_win;
   logic [GW-1:0]   arb_sel;
   logic            arb_found;
   int unsigned     arb_idx;

   assign grant_active = (state == GRANT);

   // Handshake of the granted requester and detection of the grant's last cycle
   always_comb begin
      accept    = grant_active & req_valid[grant_id] & ~fifo_full;
      grant_end = grant_active &
                  (~req_valid[grant_id] |
                   (accept & (beat_cnt == BW'(MAX_BURST - 1))));
   end

   // Round-robin pick: first valid index after arb_ptr, wrapping; arb_ptr itself is checked last
   always_comb begin
      arb_ptr   = grant_active ? grant_id : last_grant;
      arb_win   = '0;
      arb_found = 1'b0;
      arb_idx   = 0;
      arb_sel   = '0;
      for (int unsigned off = 1; off <= NR; off++) begin
         arb_idx = (32'(arb_ptr) + off) % NR;
         arb_sel = arb_idx[GW-1:0];
         if (!arb_found && req_valid[arb_sel]) begin
            arb_found = 1'b1;
            arb_win   = arb_sel;
         end
      end
   end

   // State register: FSM state, current grant, beat counter and round-robin pointer
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         grant_id   <= '0;
         beat_cnt   <= '0;
         last_grant <= GW'(NUM_REQ - 1);
      end else begin
         state      <= state_nxt;
         grant_id   <= grant_id_nxt;
         beat_cnt   <= beat_cnt_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // Next-state logic: a grant end re-arbitrates in the same cycle so there is no dead cycle between grants
   always_comb begin
      state_nxt      = state;
      grant_id_nxt   = grant_id;
      beat_cnt_nxt   = beat_cnt;
      last_grant_nxt = last_grant;
      unique case (state)
         IDLE: begin
            if (arb_found) begin
               state_nxt    = GRANT;
               grant_id_nxt = arb_win;
               beat_cnt_nxt = '0;
            end
         end
         GRANT: begin
            if (grant_end) begin
               last_grant_nxt = grant_id;
               beat_cnt_nxt   = '0;
               if (arb_found) begin
                  grant_id_nxt = arb_win;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (accept) begin
               beat_cnt_nxt = beat_cnt + BW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: ready/data steering for the granted requester only
   always_comb begin
      req_ready  = '0;
      fifo_din   = '0;
      fifo_wr_en = accept;
      for (int unsigned i = 0; i < NR; i++) begin
         if (grant_active && (grant_id == GW'(i))) begin
            req_ready[i] = ~fifo_full;
            fifo_din     = req_data[i*DW +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed, self-checking bench for fifo_wr_arbiter
// (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4). Inputs change on the falling edge,
// outputs are checked 1 ns later, so the rising edge always sees settled inputs.
module tb_fifo_wr_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        fifo_full;
   logic        fifo_wr_en;
   logic [7:0]  fifo_din;
   logic        grant_active;
   logic [1:0]  grant_id;

   int n_assert = 0;
   int n_fail   = 0;

   fifo_wr_arbiter #(
      .NUM_REQ    (4),
      .DATA_WIDTH (8),
      .MAX_BURST  (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .fifo_full    (fifo_full),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_din     (fifo_din),
      .grant_active (grant_active),
      .grant_id     (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check every output; grant_id is only meaningful while a grant is held
   task automatic expect_out(input string tag, input logic ga, input logic [1:0] gid,
                             input logic wr, input logic [7:0] din, input logic [3:0] rdy);
      chk({tag, ".grant_active"}, 32'(grant_active), 32'(ga));
      if (ga) chk({tag, ".grant_id"}, 32'(grant_id), 32'(gid));
      chk({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(wr));
      chk({tag, ".din"},   32'(fifo_din),   32'(din));
      chk({tag, ".ready"}, 32'(req_ready),  32'(rdy));
   endtask

   // Apply one cycle of inputs at the falling edge and let them settle
   task automatic step(input logic [3:0] v, input logic full, input logic [31:0] d);
      @(negedge clk);
      req_valid = v;
      fifo_full = full;
      req_data  = d;
      #1;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset     = 1'b0;
      req_valid = '0;
      fifo_full = 1'b0;
      #1;
      expect_out(tag, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      #1;
      expect_out("rst0", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      chk("rst0.grant_id", 32'(grant_id), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Single requester 1: C4, C4, FF then valid drops
      step(4'b0010, 1'b0, 32'h0000_C400);
      expect_out("t1.arb", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      step(4'b0010, 1'b0, 32'h0000_C400);
      expect_out("t1.b0", 1'b1, 2'd1, 1'b1, 8'hC4, 4'b0010);
      step(4'b0010, 1'b0, 32'h0000_C400);
      expect_out("t1.b1", 1'b1, 2'd1, 1'b1, 8'hC4, 4'b0010);
      step(4'b0010, 1'b0, 32'h0000_FF00);
      expect_out("t1.b2", 1'b1, 2'd1, 1'b1, 8'hFF, 4'b0010);
      step(4'b0000, 1'b0, 32'h0000_FF00);
      expect_out("t1.drop", 1'b1, 2'd1, 1'b0, 8'hFF, 4'b0010);
      step(4'b0000, 1'b0, 32'h0000_FF00);
      expect_out("t1.idle", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);

      // All four valid: grants 0,1,2,3,0 with four beats each, back to back
      do_reset("t2.rst");
      step(4'b1111, 1'b0, 32'hD3D2_D1D0);
      expect_out("t2.arb", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      for (int k = 0; k < 5; k++) begin
         for (int b = 0; b < 4; b++) begin
            logic [1:0] g;
            g = 2'(k % 4);
            step(4'b1111, 1'b0, 32'hD3D2_D1D0);
            expect_out($sformatf("t2.g%0d.b%0d", k, b), 1'b1, g, 1'b1,
                       8'hD0 + 8'(g), 4'(4'b0001 << g));
         end
      end
      step(4'b0000, 1'b0, 32'hD3D2_D1D0);
      expect_out("t2.drop", 1'b1, 2'd1, 1'b0, 8'hD1, 4'b0010);
      step(4'b0000, 1'b0, 32'hD3D2_D1D0);
      expect_out("t2.idle", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);

      // FIFO full stall on requester 0 while 2 waits; count resumes after stall
      do_reset("t3.rst");
      step(4'b0101, 1'b0, 32'h00B2_00A0);
      expect_out("t3.arb", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      step(4'b0101, 1'b0, 32'h00B2_00A0);
      expect_out("t3.b0", 1'b1, 2'd0, 1'b1, 8'hA0, 4'b0001);
      step(4'b0101, 1'b0, 32'h00B2_00A0);
      expect_out("t3.b1", 1'b1, 2'd0, 1'b1, 8'hA0, 4'b0001);
      for (int s = 0; s < 3; s++) begin
         step(4'b0101, 1'b1, 32'h00B2_00A0);
         expect_out($sformatf("t3.full%0d", s), 1'b1, 2'd0, 1'b0, 8'hA0, 4'b0000);
      end
      step(4'b0101, 1'b0, 32'h00B2_00A0);
      expect_out("t3.b2", 1'b1, 2'd0, 1'b1, 8'hA0, 4'b0001);
      step(4'b0101, 1'b1, 32'h00B2_00A0);
      expect_out("t3.full3", 1'b1, 2'd0, 1'b0, 8'hA0, 4'b0000);
      step(4'b0101, 1'b0, 32'h00B2_00A0);
      expect_out("t3.b3", 1'b1, 2'd0, 1'b1, 8'hA0, 4'b0001);
      step(4'b0101, 1'b0, 32'h00B2_00A0);
      expect_out("t3.rot", 1'b1, 2'd2, 1'b1, 8'hB2, 4'b0100);
      step(4'b0000, 1'b0, 32'h00B2_00A0);
      expect_out("t3.drop", 1'b1, 2'd2, 1'b0, 8'hB2, 4'b0100);

      // Early valid drop on 3, wrap-around priority to 0
      step(4'b1000, 1'b0, 32'hE300_00A0);
      expect_out("t4.arb", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      step(4'b1001, 1'b0, 32'hE300_00A0);
      expect_out("t4.b0", 1'b1, 2'd3, 1'b1, 8'hE3, 4'b1000);
      step(4'b1001, 1'b0, 32'hE300_00A0);
      expect_out("t4.b1", 1'b1, 2'd3, 1'b1, 8'hE3, 4'b1000);
      step(4'b0001, 1'b0, 32'hE300_00A0);
      expect_out("t4.drop", 1'b1, 2'd3, 1'b0, 8'hE3, 4'b1000);
      step(4'b0001, 1'b0, 32'hE300_00A0);
      expect_out("t4.wrap", 1'b1, 2'd0, 1'b1, 8'hA0, 4'b0001);
      step(4'b0000, 1'b0, 32'hE300_00A0);
      expect_out("t4.end", 1'b1, 2'd0, 1'b0, 8'hA0, 4'b0001);
      step(4'b0000, 1'b0, 32'hE300_00A0);
      expect_out("t4.idle", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);

      // Async reset mid-burst on requester 2, then 0 wins first
      step(4'b0100, 1'b0, 32'h00B2_00A0);
      expect_out("t5.arb", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      step(4'b0100, 1'b0, 32'h00B2_00A0);
      expect_out("t5.b0", 1'b1, 2'd2, 1'b1, 8'hB2, 4'b0100);
      step(4'b0100, 1'b0, 32'h00B2_00A0);
      expect_out("t5.b1", 1'b1, 2'd2, 1'b1, 8'hB2, 4'b0100);
      #2;
      reset = 1'b0;
      #1;
      expect_out("t5.async", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      chk("t5.async.grant_id", 32'(grant_id), 32'd0);
      @(negedge clk);
      reset     = 1'b1;
      req_valid = 4'b0101;
      #1;
      expect_out("t5.rel", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      step(4'b0101, 1'b0, 32'h00B2_00A0);
      expect_out("t5.first", 1'b1, 2'd0, 1'b1, 8'hA0, 4'b0001);
      step(4'b0000, 1'b0, 32'h00B2_00A0);
      expect_out("t5.drop", 1'b1, 2'd0, 1'b0, 8'hA0, 4'b0001);

      // Sole requester 2 for ten beats: re-granted at each burst limit, no gaps
      step(4'b0100, 1'b0, 32'h0020_0000);
      expect_out("t6.arb", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);
      for (int i = 0; i < 10; i++) begin
         logic [7:0] d;
         d = 8'h20 + 8'(i);
         step(4'b0100, 1'b0, {8'h00, d, 16'h0000});
         expect_out($sformatf("t6.b%0d", i), 1'b1, 2'd2, 1'b1, d, 4'b0100);
      end
      step(4'b0000, 1'b0, 32'h0029_0000);
      expect_out("t6.drop", 1'b1, 2'd2, 1'b0, 8'h29, 4'b0100);
      step(4'b0000, 1'b0, 32'h0029_0000);
      expect_out("t6.idle", 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one sync_fifo write port among NUM_REQ producers.
- Each producer has a valid/ready handshake. The arbiter grants one producer at a time, holds the grant for a burst of up to MAX_BURST beats, then rotates.
- It drives the FIFO's wr_en/din directly and back-pressures producers from the FIFO's full flag.
- Sits between producer blocks and the sync_fifo instance (DATA_WIDTH=8, FIFO_DEPTH=16).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, data width; must match the FIFO.
- MAX_BURST, 4, maximum accepted beats per grant (1..16).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester data valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- fifo_full  in  1  full flag from sync_fifo.
- fifo_wr_en  out  1  write enable to sync_fifo.
- fifo_din  out  DATA_WIDTH  write data to sync_fifo.
- grant_active  out  1  a grant is currently held.
- grant_id  out  clog2(NUM_REQ)  index of the granted requester.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, grant_active=0, grant_id=0, beat_cnt=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has top priority first.
  - Outputs forced to zero: fifo_wr_en=0, req_ready=0, fifo_din=0.
  - Applies mid-burst; a beat in flight that cycle is not written.
- States: IDLE, GRANT.
- IDLE:
  - If any req_valid, pick the first valid index scanning last_grant+1, +2, ... (modulo NUM_REQ).
  - Register grant_id, set grant_active=1, beat_cnt=0, go to GRANT.
  - One-cycle arbitration latency: no beat is accepted in IDLE.
- GRANT, with g=grant_id:
  - accept = req_valid[g] & ~fifo_full.
  - req_ready[g] = ~fifo_full; all other ready bits = 0.
  - fifo_wr_en = accept (combinational).
  - fifo_din = req_data slice g (combinational); 0 when grant_active=0.
  - Each accept increments beat_cnt.
- Grant end: either req_valid[g]=0 in GRANT (no beat that cycle), or an accept with beat_cnt==MAX_BURST-1.
  - At grant end, last_grant<=g.
  - Re-arbitrate in the same cycle from the current req_valid, with priority starting at g+1. The winner gets the grant next cycle with beat_cnt=0 and the state stays GRANT.
  - g itself is re-granted only if it is the sole valid requester after a burst-limit end.
  - If no requester is valid, go to IDLE with grant_active=0.
- fifo_full=1 while granted:
  - No accept; beat_cnt holds; grant held indefinitely while req_valid[g]=1.
  - Dropping valid during a stall ends the grant as above.
- Widths: beat_cnt is clog2(MAX_BURST)+1 bits; no wrap because it is cleared at grant end.
- Requesters must hold req_valid and data stable until ready. A valid dropped without ready is legal; it ends the grant and does not write.
- Invariant: at most one req_ready high per cycle; fifo_wr_en=1 implies fifo_full=0.

Test Plan:
- Reset then single requester:
  - Stimulus: req_valid=4'b0010, data1 sequence C4,C4,FF, then valid low.
  - Response: grant_active=1, grant_id=1 one cycle after valid. fifo_wr_en high 3 consecutive cycles with din C4,C4,FF. Then IDLE; FIFO empty=0.
- Burst limit, all four valid continuously with distinct data:
  - Grants rotate 0,1,2,3,0. Each grant gives exactly 4 wr_en beats.
  - No idle cycle between grants; exactly one req_ready high per cycle.
- FIFO full stall:
  - Stimulus: fill the FIFO to 16 entries via requester 0 while requester 2 is also valid.
  - Response: wr_en=0 and req_ready=0 while full; grant_id holds. After one FIFO read, the next beat is accepted and beat_cnt resumes, not restarts.
- Early valid drop:
  - Stimulus: requester 3 valid for 2 beats, then low; requester 0 valid.
  - Response: 2 writes from 3, then grant_id=0 next cycle (wrap-around priority 3->0).
- Async reset mid-burst:
  - Stimulus: assert reset=0 between clock edges during beat 2 of a burst.
  - Response: wr_en, req_ready, grant_active go to 0 immediately. After release, requester 0 wins first regardless of the prior grant.
- Sole requester re-grant:
  - Stimulus: only requester 2 valid for 10 beats.
  - Response: grant_id stays 2. Writes 4,4,2 with no dead cycles. IDLE after valid drops.
